// File: rtl/cpu_pkg.sv
// Shared CPU constants: bus widths, program entry point and the fetch state encoding.
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0010;

  localparam logic [1:0] ST_READ = 2'd0;
  localparam logic [1:0] ST_PUSH = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Sequential fetch wraps FFFF -> 0000 with no carry out.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: memory instruction port, decode handshake and execute redirect.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic              mem_busy;
  logic              i_read;
  logic              i_push;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] d_bus;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              jump_valid;
  logic [ADDR_W-1:0] jump_target;

  modport master (
    input  mem_busy, d_bus, instr_ready, jump_valid, jump_target,
    output i_read, i_push, i_addr, instr, instr_pc, instr_valid
  );

  modport slave (
    output mem_busy, d_bus, instr_ready, jump_valid, jump_target,
    input  i_read, i_push, i_addr, instr, instr_pc, instr_valid
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequences the memory's read/push pair, holds one instruction
// for decode, and lets execute redirect the PC at any time.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              valid_q;

  logic              do_read;
  logic              do_push;
  logic              accept;
  logic              mem_free;

  // A jump or a data access suppresses both memory strobes in the same cycle.
  always_comb begin
    mem_free = rst_n & ~bus.mem_busy & ~bus.jump_valid;
    do_read  = mem_free & (state == ST_READ);
    do_push  = mem_free & (state == ST_PUSH);
    accept   = (state == ST_HOLD) & valid_q & bus.instr_ready & ~bus.jump_valid;
  end

  assign bus.i_read      = do_read;
  assign bus.i_push      = do_push;
  assign bus.i_addr      = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q & ~bus.jump_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_READ;
      pc         <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else if (bus.jump_valid) begin
      pc      <= bus.jump_target;
      valid_q <= 1'b0;
      state   <= ST_READ;
    end else begin
      case (state)
        ST_READ: begin
          if (do_read) state <= ST_PUSH;
        end
        // A stalled push keeps its word: the memory's instruction store ignores data traffic.
        ST_PUSH: begin
          if (do_push) begin
            instr_q    <= bus.d_bus;
            instr_pc_q <= pc;
            pc         <= pc_inc(pc);
            valid_q    <= 1'b1;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (accept) begin
            valid_q <= 1'b0;
            state   <= ST_READ;
          end
        end
        default: state <= ST_READ;
      endcase
    end
  end

  a_no_dual_strobe: assert property (@(posedge clk) !(bus.i_read && bus.i_push));
  a_no_strobe_busy: assert property (@(posedge clk) bus.mem_busy |-> !(bus.i_read || bus.i_push));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a cycle table with a memory model and scoreboard, then a random soak.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  logic mon_en;

  int errors;
  int checks;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0010) return 16'hA000;
    if (a == 16'h0011) return 16'hB014;
    return a ^ 16'h5A5A;
  endfunction

  // Memory instruction store: latched on i_read, driven onto d_bus on i_push.
  logic [15:0] store_q;
  always @(posedge clk) if (bus.i_read) store_q <= mem_word(bus.i_addr);
  assign bus.d_bus = bus.i_push ? store_q : 16'hDEAD;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic [15:0] pc;
  } sb_t;

  sb_t         sb[$];
  logic [15:0] exp_pc;
  logic        stall_q;
  logic [15:0] held_instr;

  // Transaction monitor: tracks the expected PC and checks every delivered instruction.
  always @(negedge clk) begin
    if (mon_en) begin
      sb_t e;
      check_output("dual_strobe", {15'd0, bus.i_read & bus.i_push}, 16'd0);
      check_output("strobe_blocked",
                   {15'd0, (bus.i_read | bus.i_push) & (bus.mem_busy | bus.jump_valid | ~rst_n)}, 16'd0);
      if (stall_q && bus.instr_valid) check_output("instr_stable", bus.instr, held_instr);
      if (!rst_n) begin
        sb.delete();
        exp_pc = 16'h0010;
      end else if (bus.jump_valid) begin
        check_output("valid_masked", {15'd0, bus.instr_valid}, 16'd0);
        sb.delete();
        exp_pc = bus.jump_target;
      end else begin
        if (bus.i_read) check_output("read_addr", bus.i_addr, exp_pc);
        if (bus.i_push) begin
          check_output("push_addr", bus.i_addr, exp_pc);
          e.word = mem_word(exp_pc);
          e.pc   = exp_pc;
          sb.push_back(e);
          exp_pc = exp_pc + 16'd1;
        end
        if (bus.instr_valid && bus.instr_ready) begin
          if (sb.size() == 0) begin
            check_output("unexpected_instr", bus.instr_pc, 16'hXXXX);
          end else begin
            e = sb.pop_front();
            check_output("instr", bus.instr, e.word);
            check_output("instr_pc", bus.instr_pc, e.pc);
          end
        end
      end
      stall_q    = rst_n & bus.instr_valid & ~bus.instr_ready;
      held_instr = bus.instr;
    end
  end

  typedef struct {
    logic        rst;
    logic        busy;
    logic        jv;
    logic [15:0] jt;
    logic        rdy;
    logic        e_read;
    logic        e_push;
    logic        e_valid;
    logic [15:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic b, input logic j, input logic [15:0] t,
                              input logic y, input logic er, input logic ep, input logic ev,
                              input logic [15:0] ea);
    vec_t v;
    v.rst = r; v.busy = b; v.jv = j; v.jt = t; v.rdy = y;
    v.e_read = er; v.e_push = ep; v.e_valid = ev; v.e_addr = ea;
    return v;
  endfunction

  task automatic apply_stimulus(input logic r, input logic b, input logic j,
                                input logic [15:0] t, input logic y);
    rst_n           = r;
    bus.mem_busy    = b;
    bus.jump_valid  = j;
    bus.jump_target = t;
    bus.instr_ready = y;
  endtask

  task automatic wait_valid(input int budget);
    bit seen;
    seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (bus.instr_valid) seen = 1;
      @(posedge clk); #1;
    end
    check_output("valid_timeout", {15'd0, seen}, 16'd1);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    mon_en  = 0;
    stall_q = 0;
    exp_pc  = 16'h0010;
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_output("rst_instr", bus.instr, 16'h0000);
    check_output("rst_instr_pc", bus.instr_pc, 16'h0000);
    check_output("rst_valid", {15'd0, bus.instr_valid}, 16'd0);
    check_output("rst_strobes", {14'd0, bus.i_read, bus.i_push}, 16'd0);
    check_output("rst_addr", bus.i_addr, 16'h0010);

    //           rst busy jv  target    rdy  read push valid addr
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0010));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0010));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0011));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 1, 16'h0011));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0011));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 0, 0, 0, 16'h0011));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0011));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 1, 16'h0012));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0012));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0012));
    vecs.push_back(mk(1, 0, 1, 16'h0002, 1, 0, 0, 0, 16'h0013));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0002));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 0, 16'h0002));
    vecs.push_back(mk(1, 1, 1, 16'hFFFF, 0, 0, 0, 0, 16'h0003));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 0, 0, 0, 16'hFFFF));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'hFFFF));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 0, 16'hFFFF));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 1, 16'h0001));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0001));
    vecs.push_back(mk(1, 0, 1, 16'h0040, 1, 0, 0, 0, 16'h0001));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0040));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0040));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0010));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0010));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 1, 16'h0011));

    @(posedge clk);
    #1;
    mon_en = 1;
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].rst, vecs[i].busy, vecs[i].jv, vecs[i].jt, vecs[i].rdy);
      @(negedge clk);
      check_output($sformatf("i_read[%0d]", i), {15'd0, bus.i_read}, {15'd0, vecs[i].e_read});
      check_output($sformatf("i_push[%0d]", i), {15'd0, bus.i_push}, {15'd0, vecs[i].e_push});
      check_output($sformatf("valid[%0d]", i), {15'd0, bus.instr_valid}, {15'd0, vecs[i].e_valid});
      check_output($sformatf("i_addr[%0d]", i), bus.i_addr, vecs[i].e_addr);
      @(posedge clk);
      #1;
    end

    // Reset again, then the first instruction must appear within a small cycle budget.
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    wait_valid(10);
    check_output("post_rst_instr", bus.instr, 16'hA000);
    check_output("post_rst_instr_pc", bus.instr_pc, 16'h0010);

    // Random soak with data-side contention, stalls and occasional redirects.
    for (int c = 0; c < 400; c++) begin
      apply_stimulus(1'b1,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 19) == 0,
                     16'($urandom()),
                     $urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end

    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the memory block. It owns the program counter and sequences the memory's two-step instruction access: i_read latches the word, then i_push places it on the shared d_bus. It captures that word into an instruction register and hands it to decode over a valid/ready handshake. It also accepts jump redirects from execute and yields the memory to data accesses.

Parameters:
ADDR_W, 16, width of PC and i_addr
DATA_W, 16, instruction width, equal to the d_bus width
RESET_PC, 16'h0010, PC value loaded at reset (program entry word)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
mem_busy  in  1  data side owns memory this cycle (d_read/d_write/d_push); fetch must not assert i_read or i_push
i_read  out  1  to memory: latch mem[i_addr] into its instruction store at the next edge
i_push  out  1  to memory: drive the instruction store onto d_bus this cycle
i_addr  out  ADDR_W  to memory: fetch address, equal to pc
d_bus  in  DATA_W  shared bus, sampled only while i_push=1
instr  out  DATA_W  instruction register
instr_pc  out  ADDR_W  address instr was fetched from
instr_valid  out  1  instr holds an unconsumed instruction
instr_ready  in  1  decode accepts instr this cycle
jump_valid  in  1  redirect request from execute
jump_target  in  ADDR_W  new PC on redirect

Behaviour:
- Reset (rst_n=0 at a rising edge): state=READ, pc=RESET_PC, instr=0, instr_pc=0, valid_q=0; i_read=0 and i_push=0 while rst_n=0.
- State machine with states READ, PUSH and HOLD.
- READ: i_read = ~mem_busy & ~jump_valid; i_addr=pc. When i_read=1, go to PUSH at the next edge. Otherwise stay in READ.
- PUSH: i_push = ~mem_busy & ~jump_valid. When i_push=1, at the edge: instr<=d_bus, instr_pc<=pc, pc<=pc+1 (mod 2^ADDR_W, wrapping FFFF->0000), valid_q<=1, go to HOLD. When mem_busy=1, stay in PUSH with i_push=0. The memory's instruction store is unaffected by data accesses, so the word is preserved.
- HOLD: i_read=0 and i_push=0. On instr_valid & instr_ready: valid_q<=0, go to READ.
- Output and handshake:
  - instr_valid = valid_q & ~jump_valid (combinational mask).
  - instr is stable while instr_valid=1 and ready=0.
- Latency: with no stalls, READ at cycle N, PUSH at N+1, instr_valid at N+2. Best-case throughput is 1 instruction per 3 cycles.
- Jump (any state, highest priority):
  - At the edge: pc<=jump_target, valid_q<=0, state<=READ.
  - i_read and i_push are forced to 0 in that cycle.
  - Any in-flight fetch is discarded.
  - A handshake coinciding with jump_valid is not a transfer.
- Simultaneous mem_busy and jump_valid: the jump is taken and no memory strobe is issued.
- i_read and i_push are never asserted in the same cycle. Neither is ever asserted while mem_busy=1.
- No internal buffering beyond one instruction register.

Decomposition:
- Shared package (cpu_pkg): ADDR_W, DATA_W, RESET_PC constants and the fetch state encoding (READ=2'd0, PUSH=2'd1, HOLD=2'd2).
- Single module; no sub-module warranted. The PC incrementer is inline.

Test Plan:
- Reset then run with instr_ready=1 and a memory model (mem[16]=A000, mem[17]=B014): i_read at pc=0010, i_push the next cycle, instr=A000 with instr_pc=0010 valid 2 cycles after the first i_read; then instr=B014 with instr_pc=0011.
- Hold instr_ready=0 for 5 cycles after the first fetch -> instr_valid stays 1 and instr stays A000; no i_read or i_push in that window; pc=0011.
- Assert mem_busy in the PUSH cycle for 3 cycles -> i_push=0 for those cycles, then i_push=1; instr still A000.
- Assert jump_valid with jump_target=0002 while in HOLD with instr_ready=1 -> instr_valid=0 that cycle; the next i_read has i_addr=0002; the old instruction is not re-presented.
- Jump to FFFF and fetch two words -> second i_addr=0000 (wrap); instr_pc values FFFF then 0000.
- Drop rst_n for 1 cycle mid-PUSH -> next cycle: instr_valid=0, state READ, i_addr=0010; no i_push during reset.
